fetch_queue_unit: RTL and testbench

- Parametrised next-generation fetch stage: owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {pc, inst} pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirects (branch/jump) with a flush of buffered and in-flight fetches; decodes the immediate of the head instruction.
- Sits between imem and the decode/execute stage.

---
 rtl/fetch_queue_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency imem, and buffers {pc, inst} for decode.
// Optional perf counters (perf_fetched/perf_flushed) are enabled by defining FETCH_PERF_COUNTERS_EN.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module fetch_queue_unit #(
  parameter int          IMEM_AWIDTH = 32,
  parameter logic [31:0] RESET_PC    = `PC_RESET,
  parameter int          BUF_DEPTH   = 2,
  parameter int          PERF_CW     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  output logic                   imem_re,
  input  logic [31:0]            imem_inst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  input  logic [2:0]             immediate_select,
  output logic [31:0]            immediate_out
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [PERF_CW-1:0]     perf_fetched,
  output logic [PERF_CW-1:0]     perf_flushed
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [31:0] imm_decode(input logic [31:0] inst, input logic [2:0] sel);
    logic [31:0] imm;
    case (sel)
      3'd0:    imm = {{20{inst[31]}}, inst[31:20]};
      3'd1:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd2:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3:    imm = {inst[31:12], 12'h000};
      3'd4:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic          r_inflight;
  logic [31:0]   r_fifo_pc   [BUF_DEPTH];
  logic [31:0]   r_fifo_inst [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [31:0]   w_target;
  logic [31:0]   w_issue_pc;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_lim;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_target  = redirect_pc & 32'hFFFF_FFFC;
  // A response returning in a redirect cycle belongs to the old path and is dropped.
  assign w_push    = r_inflight && !redirect_valid;

  // Issue decision: a slot must exist for every outstanding response.
  always_comb begin
    w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_lim      = (CW + 1)'(BUF_DEPTH) + {{CW{1'b0}}, w_pop};
    w_issue    = !rst && (redirect_valid || (w_occ < w_lim));
    w_issue_pc = redirect_valid ? w_target : r_fetch_pc;
    imem_re    = w_issue;
    if (rst) begin
      imem_addr = RESET_PC[IMEM_AWIDTH-1:0];
    end else begin
      imem_addr = w_issue_pc[IMEM_AWIDTH-1:0];
    end
  end

  // PC, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target + 32'd4;
      r_resp_pc  <= w_target;
      r_inflight <= 1'b1;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_resp_pc  <= r_fetch_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are qualified by r_count so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_inst[r_wr_ptr] <= imem_inst;
    end
  end

  assign out_pc        = out_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0000_0000;
  assign out_inst      = out_valid ? r_fifo_inst[r_rd_ptr] : 32'h0000_0000;
  assign immediate_out = imm_decode(out_inst, immediate_select);

`ifdef FETCH_PERF_COUNTERS_EN
  function automatic logic [PERF_CW-1:0] sat_add(input logic [PERF_CW-1:0] a, input logic [CW:0] b);
    logic [PERF_CW:0] s;
    s = {1'b0, a} + (PERF_CW + 1)'(b);
    return s[PERF_CW] ? {PERF_CW{1'b1}} : s[PERF_CW-1:0];
  endfunction

  logic [CW:0] w_flush_n;
  // An entry popped in the redirect cycle was handed off, so it is not counted as flushed.
  assign w_flush_n = {1'b0, r_count} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_inflight};

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (w_pop) begin
        perf_fetched <= sat_add(perf_fetched, (CW + 1)'(1));
      end
      if (redirect_valid) begin
        perf_flushed <= sat_add(perf_flushed, w_flush_n);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: scoreboard of expected PCs plus timed corner sequences.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  immediate_select;
  logic [31:0] immediate_out;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] special_inst = 32'h0000_0000;
  logic [31:0] r_mem_data   = 32'h0000_0000;
  logic [31:0] exp_q[$];
  logic [31:0] exp_next     = 32'h0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [31:0] exp;
  } imm_vec_t;
  imm_vec_t vecs[9];

  fetch_queue_unit #(
    .IMEM_AWIDTH(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2), .PERF_CW(32)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .immediate_select(immediate_select), .immediate_out(immediate_out)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_mem(input logic [31:0] a);
    return (a == 32'h0000_0400) ? special_inst : (a ^ 32'hA5A5_A5A5);
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_re) r_mem_data <= tb_mem(imem_addr);
  end
  assign imem_inst = r_mem_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake must deliver the next PC of the current path.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      exp_next = 32'h0000_0000;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_underflow", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", out_pc, e);
          check("pop_inst", out_inst, tb_mem(e));
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_next = redirect_pc & 32'hFFFF_FFFC;
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  end

  initial begin
    vecs[0] = '{32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC};  // beq x0,x0,-4
    vecs[1] = '{32'hFE00_0EE3, 3'd7, 32'h0000_0000};
    vecs[2] = '{32'h8000_0013, 3'd0, 32'hFFFF_F800};
    vecs[3] = '{32'h7FF0_0013, 3'd0, 32'h0000_07FF};
    vecs[4] = '{32'h00A0_0223, 3'd1, 32'h0000_0004};
    vecs[5] = '{32'h00A0_0223, 3'd0, 32'h0000_000A};
    vecs[6] = '{32'h1234_5037, 3'd3, 32'h1234_5000};
    vecs[7] = '{32'h1234_5037, 3'd5, 32'h0000_0000};
    vecs[8] = '{32'hFFDF_F06F, 3'd4, 32'hFFFF_FFFC};

    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    immediate_select = 3'd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_imem_re", {31'h0, imem_re}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
`endif

    // Reset release with decode always ready.
    tick(); rst = 1'b0;
    @(negedge clk);
    check("c0_imem_re", {31'h0, imem_re}, 32'h1);
    check("c0_imem_addr", imem_addr, 32'h0);
    check("c0_out_valid", {31'h0, out_valid}, 32'h0);
    tick(); @(negedge clk);
    check("c1_out_valid", {31'h0, out_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      check("stream_valid", {31'h0, out_valid}, 32'h1);
      check("stream_pc", out_pc, 32'(4 * k));
    end

    // Redirect while streaming (in-flight response killed); low bits ignored.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_re", {31'h0, imem_re}, 32'h1);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_gap", {31'h0, out_valid}, 32'h0);
    tick(); @(negedge clk);
    check("redir_first", out_pc, 32'h0000_0100);
    tick(); @(negedge clk);
    check("redir_second", out_pc, 32'h0000_0104);

    // Back-to-back redirects: the later one wins.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick(); redirect_pc = 32'h0000_0300;
    @(negedge clk);
    check("b2b_addr", imem_addr, 32'h0000_0300);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_gap", {31'h0, out_valid}, 32'h0);
    tick(); @(negedge clk);
    check("b2b_valid", {31'h0, out_valid}, 32'h1);
    check("b2b_first", out_pc, 32'h0000_0300);

    // Backpressure: only two fetches outstanding, head stays stable.
    tick(); rst = 1'b1; out_ready = 1'b0;
    tick(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("stall_re", {31'h0, imem_re}, 32'h0);
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        check("stall_pc", out_pc, 32'h0);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_pc0", out_pc, 32'h0);
    tick(); @(negedge clk);
    check("rel_pc4", out_pc, 32'h4);
    tick(); out_ready = 1'b0;
    @(negedge clk);
    check("rel_valid8", {31'h0, out_valid}, 32'h1);
    check("rel_pc8", out_pc, 32'h8);
    tick(); tick();
    @(negedge clk);
    check("full_head", out_pc, 32'h8);
    check("full_re", {31'h0, imem_re}, 32'h0);

    // Redirect with a full FIFO and a pop in the same cycle.
    tick(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("full_redir_gap", {31'h0, out_valid}, 32'h0);
    tick(); @(negedge clk);
    check("full_redir_first", out_pc, 32'h0000_0100);
    tick(); @(negedge clk);
    check("full_redir_second", out_pc, 32'h0000_0104);

    // Immediate decode vectors, instruction placed at 0x400.
    for (int i = 0; i < 9; i++) begin
      tick(); out_ready = 1'b0; special_inst = vecs[i].inst;
      immediate_select = vecs[i].sel;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
      tick(); redirect_valid = 1'b0;
      tick(); @(negedge clk);
      check("imm_pc", out_pc, 32'h0000_0400);
      check("imm_inst", out_inst, vecs[i].inst);
      check("imm_value", immediate_out, vecs[i].exp);
    end

    // Reset mid-stream.
    tick(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick(); redirect_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_re", {31'h0, imem_re}, 32'h1);
`ifdef FETCH_PERF_COUNTERS_EN
    check("mid_rst_perf_fetched", perf_fetched, 32'h0);
    check("mid_rst_perf_flushed", perf_flushed, 32'h0);
`endif
    tick(); @(negedge clk);
    check("mid_rst_gap", {31'h0, out_valid}, 32'h0);
    tick(); @(negedge clk);
    check("mid_rst_first", out_pc, 32'h0);
    tick(); @(negedge clk);
    check("mid_rst_second", out_pc, 32'h4);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
